// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: loads the MAR from the PC, issues a memory read,
// captures the returned word for decode and handles branch redirects, including mid-read ones.
module fetch_sequencer #(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en_i,
    output logic              mar_wr_o,
    output logic              mar_rd_o,
    output logic [ADDR_W-1:0] mar_addin_o,
    output logic              mem_req_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [DATA_W-1:0] instr_o,
    output logic [ADDR_W-1:0] instr_pc_o,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic [ADDR_W-1:0] pc_o
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_MAR = 3'd1,
        ISSUE    = 3'd2,
        MEM_WAIT = 3'd3,
        HOLD     = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                flush_q, flush_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;
    logic                valid_q, valid_d;
    logic                mar_wr_q, mar_wr_d;
    logic                mar_rd_q, mar_rd_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mar_addin_q, mar_addin_d;

    // State register; strobes are registered from the next state so they track state_q exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= ADDR_W'(RESET_PC);
            flush_q     <= 1'b0;
            instr_q     <= '0;
            instr_pc_q  <= '0;
            valid_q     <= 1'b0;
            mar_wr_q    <= 1'b0;
            mar_rd_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mar_addin_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            flush_q     <= flush_d;
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
            valid_q     <= valid_d;
            mar_wr_q    <= mar_wr_d;
            mar_rd_q    <= mar_rd_d;
            mem_req_q   <= mem_req_d;
            mar_addin_q <= mar_addin_d;
        end
    end

    // Next-state and datapath control; redirect wins over every other event.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        flush_d    = flush_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;

        case (state_q)
            IDLE: begin
                if (redirect_i) pc_d = redirect_pc_i;
                if (fetch_en_i) state_d = LOAD_MAR;
            end
            LOAD_MAR: begin
                if (redirect_i) begin
                    pc_d    = redirect_pc_i;
                    state_d = LOAD_MAR;
                end else begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (redirect_i) begin
                    pc_d    = redirect_pc_i;
                    state_d = LOAD_MAR;
                end else begin
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (redirect_i) begin
                    pc_d = redirect_pc_i;
                    if (mem_ack_i) begin
                        flush_d = 1'b0;
                        state_d = LOAD_MAR;
                    end else begin
                        flush_d = 1'b1;
                    end
                end else if (mem_ack_i) begin
                    if (flush_q) begin
                        flush_d = 1'b0;
                        state_d = LOAD_MAR;
                    end else begin
                        instr_d    = mem_rdata_i;
                        instr_pc_d = pc_q;
                        pc_d       = pc_q + ADDR_W'(1);
                        valid_d    = 1'b1;
                        state_d    = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect_i || instr_ready_i) begin
                    valid_d = 1'b0;
                    state_d = fetch_en_i ? LOAD_MAR : IDLE;
                    if (redirect_i) pc_d = redirect_pc_i;
                end
            end
            default: state_d = IDLE;
        endcase

        mar_wr_d    = (state_d == LOAD_MAR);
        mar_rd_d    = (state_d == ISSUE);
        mem_req_d   = (state_d == MEM_WAIT);
        mar_addin_d = (state_d == LOAD_MAR) ? pc_d : '0;
    end

    assign mar_wr_o      = mar_wr_q;
    assign mar_rd_o      = mar_rd_q;
    assign mar_addin_o   = mar_addin_q;
    assign mem_req_o     = mem_req_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign instr_valid_o = valid_q;
    assign pc_o          = pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a small MAR/memory model and hand-computed expectations.
module tb_fetch_sequencer;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;

    logic              clk;
    logic              rst_n;
    logic              fetch_en;
    logic              mar_wr;
    logic              mar_rd;
    logic [ADDR_W-1:0] mar_addin;
    logic              mem_req;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic [ADDR_W-1:0] pc;

    logic              auto_ack;
    logic              man_ack;
    logic              auto_data;
    logic [DATA_W-1:0] man_data;
    logic [ADDR_W-1:0] mar_q;

    int n_chk;
    int n_err;

    fetch_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_en_i    (fetch_en),
        .mar_wr_o      (mar_wr),
        .mar_rd_o      (mar_rd),
        .mar_addin_o   (mar_addin),
        .mem_req_o     (mem_req),
        .mem_ack_i     (mem_ack),
        .mem_rdata_i   (mem_rdata),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc),
        .instr_valid_o (instr_valid),
        .instr_ready_i (instr_ready),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .pc_o          (pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // MAR and zero-wait memory model: data word is 0xA0000000 + address.
    always @(posedge clk) if (mar_wr) mar_q <= mar_addin;
    assign mem_ack   = auto_ack ? mem_req : man_ack;
    assign mem_rdata = auto_data ? (32'hA000_0000 | 32'(mar_q)) : man_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Free-running fetch pattern starting in LOAD_MAR at address base.
    task automatic seq(input int base, input int n);
        logic [ADDR_W-1:0] a;
        for (int k = 0; k < n; k++) begin
            a = ADDR_W'(base + k / 4);
            check("seq_mar_wr", 32'(mar_wr), 32'(k % 4 == 0));
            if (k % 4 == 0) check("seq_mar_addin", 32'(mar_addin), 32'(a));
            check("seq_mar_rd", 32'(mar_rd), 32'(k % 4 == 1));
            check("seq_mem_req", 32'(mem_req), 32'(k % 4 == 2));
            check("seq_valid", 32'(instr_valid), 32'(k % 4 == 3));
            if (k % 4 == 3) begin
                check("seq_instr_pc", 32'(instr_pc), 32'(a));
                check("seq_instr", instr, 32'hA000_0000 | 32'(a));
            end
            step();
        end
    endtask

    task automatic check_all_zero(input logic [ADDR_W-1:0] exp_pc);
        check("rst_mar_wr", 32'(mar_wr), 32'd0);
        check("rst_mar_rd", 32'(mar_rd), 32'd0);
        check("rst_mar_addin", 32'(mar_addin), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", 32'(instr_pc), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_pc", 32'(pc), 32'(exp_pc));
    endtask

    initial begin
        n_chk = 0; n_err = 0;
        rst_n = 1'b0; fetch_en = 1'b0; instr_ready = 1'b0;
        redirect = 1'b0; redirect_pc = '0;
        auto_ack = 1'b1; man_ack = 1'b0; auto_data = 1'b1; man_data = '0;

        #12;
        check_all_zero(5'd0);
        rst_n = 1'b1; fetch_en = 1'b1; instr_ready = 1'b1;
        step();

        // Zero-wait back-to-back fetches of 0,1,2.
        seq(0, 12);
        check("pc_after_3", 32'(pc), 32'd3);

        // Slow memory (5 cycles of mem_req) and slow decode (3 stall cycles).
        auto_ack = 1'b0; auto_data = 1'b0; man_data = 32'h1234_5678; instr_ready = 1'b0;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            check("slow_mem_req", 32'(mem_req), 32'd1);
            check("slow_no_valid", 32'(instr_valid), 32'd0);
            if (i == 4) man_ack = 1'b1;
            step();
        end
        man_ack = 1'b0;
        check("slow_req_drop", 32'(mem_req), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("hold_valid", 32'(instr_valid), 32'd1);
            check("hold_instr", instr, 32'h1234_5678);
            check("hold_instr_pc", 32'(instr_pc), 32'd3);
            check("hold_pc", 32'(pc), 32'd4);
            if (i == 3) instr_ready = 1'b1;
            step();
        end
        instr_ready = 1'b0;
        check("hold_release_valid", 32'(instr_valid), 32'd0);
        check("hold_release_addin", 32'(mar_addin), 32'd4);
        check("pc_once", 32'(pc), 32'd4);

        // Redirect while the read is in flight: late data must be dropped.
        step();
        step();
        redirect = 1'b1; redirect_pc = 5'h10; man_data = 32'hDEAD_BEEF;
        check("flush_req_before", 32'(mem_req), 32'd1);
        step();
        redirect = 1'b0;
        check("flush_req_held", 32'(mem_req), 32'd1);
        check("flush_pc", 32'(pc), 32'h10);
        step();
        man_ack = 1'b1;
        check("flush_no_valid", 32'(instr_valid), 32'd0);
        step();
        man_ack = 1'b0;
        check("flush_drop_valid", 32'(instr_valid), 32'd0);
        check("flush_instr_kept", instr, 32'h1234_5678);
        check("flush_mar_wr", 32'(mar_wr), 32'd1);
        check("flush_mar_addin", 32'(mar_addin), 32'h10);
        auto_ack = 1'b1; auto_data = 1'b1;
        step();
        step();
        step();
        check("redir_valid", 32'(instr_valid), 32'd1);
        check("redir_instr_pc", 32'(instr_pc), 32'h10);
        check("redir_instr", instr, 32'hA000_0010);
        check("redir_pc", 32'(pc), 32'h11);

        // Redirect together with accept in HOLD, then sequential wrap 31 -> 0.
        redirect = 1'b1; redirect_pc = 5'h1F; instr_ready = 1'b1;
        step();
        redirect = 1'b0;
        seq(31, 8);
        check("wrap_pc", 32'(pc), 32'd1);

        // Asynchronous reset while a read is outstanding.
        auto_ack = 1'b0;
        step();
        step();
        check("pre_rst_req", 32'(mem_req), 32'd1);
        check("pre_rst_instr", instr, 32'hA000_0000);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero(5'd0);
        #2;
        rst_n = 1'b1; auto_ack = 1'b1;
        step();
        seq(0, 3);
        check("restart_valid", 32'(instr_valid), 32'd1);
        check("restart_instr_pc", 32'(instr_pc), 32'd0);

        // fetch_en low parks in IDLE; redirect there only moves the PC.
        fetch_en = 1'b0;
        step();
        check("idle_valid", 32'(instr_valid), 32'd0);
        check("idle_mar_wr", 32'(mar_wr), 32'd0);
        check("idle_pc", 32'(pc), 32'd1);
        redirect = 1'b1; redirect_pc = 5'd5;
        step();
        redirect = 1'b0;
        check("idle_redir_pc", 32'(pc), 32'd5);
        check("idle_redir_mar_wr", 32'(mar_wr), 32'd0);
        step();
        check("idle_stay", 32'(mar_wr), 32'd0);
        fetch_en = 1'b1;
        step();
        check("idle_exit_mar_wr", 32'(mar_wr), 32'd1);
        check("idle_exit_addin", 32'(mar_addin), 32'd5);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controller for the instruction-fetch datapath.
- Sequences the memory address register (write, then read), issues a memory read, captures the returned 32-bit word and hands it to decode over a valid/ready handshake.
- Owns the program counter and handles branch redirects, including redirects that arrive while a memory read is in flight.
- Sits between the PC/MAR/instruction-memory datapath and the decode stage.

Parameters:
- ADDR_W, 5, address width of PC, MAR and instruction memory.
- DATA_W, 32, instruction word width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- fetch_en  input  1  allow new fetches to start.
- mar_wr  output  1  MAR write strobe.
- mar_rd  output  1  MAR read/drive strobe.
- mar_addin  output  ADDR_W  address presented to the MAR.
- mem_req  output  1  instruction memory read request; memory uses the MAR output as the address.
- mem_ack  input  1  memory data valid this cycle.
- mem_rdata  input  DATA_W  memory read data.
- instr  output  DATA_W  fetched instruction.
- instr_pc  output  ADDR_W  address of the fetched instruction.
- instr_valid  output  1  instr/instr_pc valid.
- instr_ready  input  1  decode accepts the instruction.
- redirect  input  1  branch redirect strobe.
- redirect_pc  input  ADDR_W  redirect target.
- pc  output  ADDR_W  current program counter.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; pc=RESET_PC; flush flag=0.
  - All outputs 0, except pc.
- States: IDLE, LOAD_MAR, ISSUE, MEM_WAIT, HOLD. All strobes are decoded from state (Moore); instr, instr_pc and instr_valid are registered.
- IDLE:
  - No strobes asserted.
  - fetch_en=1 → LOAD_MAR.
  - redirect → pc<=redirect_pc; stay IDLE unless fetch_en=1.
- LOAD_MAR:
  - mar_wr=1, mar_addin=pc.
  - Next state: ISSUE.
- ISSUE:
  - mar_rd=1, mar_wr=0.
  - Next state: MEM_WAIT. MAR output is valid from this edge onward.
- MEM_WAIT:
  - mem_req=1 and held until mem_ack. Unbounded wait is permitted.
  - On mem_ack with flush=0:
    - instr<=mem_rdata, instr_pc<=pc, pc<=pc+1 (mod 2^ADDR_W; 31→0 wraps), instr_valid<=1 → HOLD.
  - On mem_ack with flush=1: data discarded, flush<=0 → LOAD_MAR.
- HOLD:
  - instr_valid=1; instr and instr_pc are stable until accepted.
  - instr_ready=1 → instr_valid<=0; next state is LOAD_MAR if fetch_en=1, else IDLE.
- Redirect handling (redirect has priority over every other event in the same cycle):
  - LOAD_MAR or ISSUE: pc<=redirect_pc → LOAD_MAR.
  - MEM_WAIT without mem_ack: pc<=redirect_pc, flush<=1; mem_req stays high until mem_ack.
  - MEM_WAIT with mem_ack in the same cycle: data discarded, pc<=redirect_pc → LOAD_MAR.
  - HOLD (with or without instr_ready): instr_valid<=0, pc<=redirect_pc → LOAD_MAR (IDLE if fetch_en=0).
  - A redirect during a flush overwrites the target; flush stays 1.
- fetch_en=0 never aborts an outstanding memory request; it only blocks new fetches.
- Latency and throughput:
  - With zero-wait memory (mem_ack in the first MEM_WAIT cycle), instr_valid rises 3 cycles after entry to LOAD_MAR.
  - Back-to-back fetches complete once every 4 cycles when instr_ready is held at 1.
- mar_wr and mar_rd are never asserted together.
- Reset mid-operation: immediate return to IDLE. An outstanding memory request is abandoned, and memory must tolerate mem_req dropping.

Test Plan:
- Reset release, fetch_en=1, mem_ack immediate, instr_ready=1, mem_rdata=0xA0000000+addr → observe, in order:
  - mar_wr with addin 0, 1, 2, ….
  - instr_valid at cycles 3, 7, 11 after LOAD_MAR entry.
  - instr_pc 0, 1, 2.
- mem_ack delayed 5 cycles, instr_ready low 3 cycles → mem_req held 5 cycles; instr=0x12345678 stable throughout HOLD; pc increments exactly once.
- redirect (redirect_pc=0x10) in MEM_WAIT, mem_ack 2 cycles later with 0xDEADBEEF → no instr_valid for 0xDEADBEEF; next mar_addin=0x10; instr_pc=0x10.
- redirect together with instr_ready in HOLD → instr_valid low next cycle; next fetch from redirect_pc; no duplicate valid.
- pc=31, sequential fetch → instr_pc=31, then mar_addin=0 (wrap).
- rst_n pulsed low during MEM_WAIT → all outputs 0 within the same cycle; pc=RESET_PC; fetch restarts cleanly at address 0.
